// File: rtl/frame_grabber.sv
// frame_grabber: captures one (or every) camera frame from a VGA-style sync
// stream and emits one frame-store write per kept pixel.
// Kept pixels are chosen by power-of-two decimation, then cropped to OUT_W x OUT_H.
//
// Ports:
//   clk         single clock; sync inputs and pixel data are sampled here
//   reset       synchronous, active-low
//   start       one-cycle capture request, honoured only when idle
//   continuous  sampled with start; 1 = capture every frame until abort
//   abort       return to idle at the next edge, suppressing write/frame_done
//   iVGA_VS     0 = vertical sync pulse, 1 = frame region
//   iVGA_HS     1 = active pixel on current line
//   iPIX        pixel data, valid while iVGA_HS = 1
//   write       frame-store write strobe
//   x, y        destination column / row
//   wdata       pixel to store
//   busy        high whenever not idle
//   frame_done  one-cycle pulse per completed captured frame
//   frame_cnt   count of completed frames (wraps)
module frame_grabber #(
  parameter int unsigned PIX_W  = 24,
  parameter int unsigned DEC_X  = 1,
  parameter int unsigned DEC_Y  = 1,
  parameter int unsigned OUT_W  = 256,
  parameter int unsigned OUT_H  = 240,
  parameter int unsigned SRC_CW = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       continuous,
  input  logic                       abort,
  input  logic                       iVGA_VS,
  input  logic                       iVGA_HS,
  input  logic [PIX_W-1:0]           iPIX,
  output logic                       write,
  output logic [$clog2(OUT_W)-1:0]   x,
  output logic [$clog2(OUT_H)-1:0]   y,
  output logic [PIX_W-1:0]           wdata,
  output logic                       busy,
  output logic                       frame_done,
  output logic [7:0]                 frame_cnt
);

  localparam int unsigned XW = $clog2(OUT_W);
  localparam int unsigned YW = $clog2(OUT_H);
  localparam logic [SRC_CW-1:0] MASK_X = SRC_CW'((1 << DEC_X) - 1);
  localparam logic [SRC_CW-1:0] MASK_Y = SRC_CW'((1 << DEC_Y) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_SYNC, S_LOAD} state_t;

  state_t              r_ps, w_ns;
  logic [SRC_CW-1:0]   r_sx, r_sy, w_sx, w_sy;
  logic                r_cont, w_cont;
  logic                r_hs_d, r_vs_d;
  logic                r_write, w_write;
  logic [XW-1:0]       r_x, w_x;
  logic [YW-1:0]       r_y, w_y;
  logic [PIX_W-1:0]    r_wdata, w_wdata;
  logic                r_busy;
  logic                r_fd, w_fd;
  logic [7:0]          r_cnt, w_cnt;

  // Destination coordinates and keep/crop decision for the current source pixel
  logic [SRC_CW-1:0]   w_dx, w_dy;
  logic                w_keep, w_in_crop;

  assign w_dx      = r_sx >> DEC_X;
  assign w_dy      = r_sy >> DEC_Y;
  assign w_keep    = ((r_sx & MASK_X) == '0) && ((r_sy & MASK_Y) == '0);
  assign w_in_crop = (32'(w_dx) < OUT_W) && (32'(w_dy) < OUT_H);

  // Next-state and next-output logic
  always_comb begin
    w_ns    = r_ps;
    w_sx    = r_sx;
    w_sy    = r_sy;
    w_cont  = r_cont;
    w_write = 1'b0;
    w_x     = r_x;
    w_y     = r_y;
    w_wdata = r_wdata;
    w_fd    = 1'b0;
    w_cnt   = r_cnt;

    case (r_ps)
      S_IDLE: begin
        w_sx = '0;
        w_sy = '0;
        if (start) begin
          w_ns   = S_ARM;
          w_cont = continuous;
        end
      end
      S_ARM: begin
        // Wait for a sync pulse so capture never starts mid-frame
        if (!iVGA_VS) w_ns = S_SYNC;
      end
      S_SYNC: begin
        w_sx = '0;
        w_sy = '0;
        if (iVGA_VS) w_ns = S_LOAD;
      end
      S_LOAD: begin
        if (iVGA_HS) begin
          if (w_keep && w_in_crop) begin
            w_write = 1'b1;
            w_x     = XW'(w_dx);
            w_y     = YW'(w_dy);
            w_wdata = iPIX;
          end
          // Saturate rather than wrap so an overlong line cannot alias
          if (r_sx != '1) w_sx = r_sx + SRC_CW'(1);
        end else if (r_hs_d) begin
          // End of line: only the HS falling edge advances the line counter
          w_sx = '0;
          if (r_sy != '1) w_sy = r_sy + SRC_CW'(1);
        end
        if (r_vs_d && !iVGA_VS) begin
          w_fd  = 1'b1;
          w_cnt = r_cnt + 8'd1;
          w_ns  = r_cont ? S_SYNC : S_IDLE;
        end
      end
      default: w_ns = S_IDLE;
    endcase

    // Abort overrides every transition and output
    if (abort) begin
      w_ns    = S_IDLE;
      w_cont  = 1'b0;
      w_write = 1'b0;
      w_fd    = 1'b0;
      w_cnt   = r_cnt;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ps    <= S_IDLE;
      r_sx    <= '0;
      r_sy    <= '0;
      r_cont  <= 1'b0;
      r_hs_d  <= 1'b0;
      r_vs_d  <= 1'b0;
      r_write <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_fd    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_ps    <= w_ns;
      r_sx    <= w_sx;
      r_sy    <= w_sy;
      r_cont  <= w_cont;
      r_hs_d  <= iVGA_HS;
      r_vs_d  <= iVGA_VS;
      r_write <= w_write;
      r_x     <= w_x;
      r_y     <= w_y;
      r_wdata <= w_wdata;
      r_busy  <= (w_ns != S_IDLE);
      r_fd    <= w_fd;
      r_cnt   <= w_cnt;
    end
  end

  assign write      = r_write;
  assign x          = r_x;
  assign y          = r_y;
  assign wdata      = r_wdata;
  assign busy       = r_busy;
  assign frame_done = r_fd;
  assign frame_cnt  = r_cnt;

endmodule

// File: tb/tb_frame_grabber.sv
// tb_frame_grabber: directed bench for frame_grabber. Three instances share
// the stimulus: full-res (u0), 2x2 decimation (u1) and a 4x2 crop (u2).
// Source frames are 8x4 with pixel = {frame id, line, column}.
module tb_frame_grabber;

  logic        clk = 1'b0;
  logic        reset, start, continuous, abort, iVGA_VS, iVGA_HS;
  logic [23:0] iPIX;

  logic        w0, w1, w2, b0, b1, b2, fd0, fd1, fd2;
  logic [7:0]  x0, y0, x1, y1, c0, c1, c2;
  logic [1:0]  x2;
  logic        y2;
  logic [23:0] d0, d1, d2;

  int n_vec = 0;
  int n_err = 0;
  int k0, k1, k2;
  int wc0, wc1, wc2, fc0, fc1, bc0;

  always #5 clk = ~clk;

  frame_grabber #(.PIX_W(24), .DEC_X(0), .DEC_Y(0), .OUT_W(256), .OUT_H(240), .SRC_CW(11)) u0 (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
    .iVGA_VS(iVGA_VS), .iVGA_HS(iVGA_HS), .iPIX(iPIX), .write(w0), .x(x0), .y(y0),
    .wdata(d0), .busy(b0), .frame_done(fd0), .frame_cnt(c0));

  frame_grabber #(.PIX_W(24), .DEC_X(1), .DEC_Y(1), .OUT_W(256), .OUT_H(240), .SRC_CW(11)) u1 (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
    .iVGA_VS(iVGA_VS), .iVGA_HS(iVGA_HS), .iPIX(iPIX), .write(w1), .x(x1), .y(y1),
    .wdata(d1), .busy(b1), .frame_done(fd1), .frame_cnt(c1));

  frame_grabber #(.PIX_W(24), .DEC_X(0), .DEC_Y(0), .OUT_W(4), .OUT_H(2), .SRC_CW(11)) u2 (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
    .iVGA_VS(iVGA_VS), .iVGA_HS(iVGA_HS), .iPIX(iPIX), .write(w2), .x(x2), .y(y2),
    .wdata(d2), .busy(b2), .frame_done(fd2), .frame_cnt(c2));

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    wc0 = 0; wc1 = 0; wc2 = 0; fc0 = 0; fc1 = 0; bc0 = 0;
  endtask

  // One clock: inputs applied at negedge, outputs checked at the next negedge
  task automatic step(input logic vs, input logic hs, input logic [23:0] pix);
    iVGA_VS = vs; iVGA_HS = hs; iPIX = pix;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    if (w0) begin
      n_vec++;
      assert (x0 === 8'(k0 % 8) && y0 === 8'(k0 / 8) && d0 === pix && pix[7:0] == x0 && pix[15:8] == y0) else begin
        n_err++;
        $error("FAIL u0_wr k=%0d got x=%0d y=%0d d=%h exp x=%0d y=%0d d=%h", k0, x0, y0, d0, k0 % 8, k0 / 8, pix);
      end
      k0++; wc0++;
    end
    if (w1) begin
      n_vec++;
      assert (x1 === 8'(k1 % 4) && y1 === 8'(k1 / 4) && d1 === pix && pix[7:0] == 8'(2 * x1) && pix[15:8] == 8'(2 * y1)) else begin
        n_err++;
        $error("FAIL u1_wr k=%0d got x=%0d y=%0d d=%h exp x=%0d y=%0d src=%h", k1, x1, y1, d1, k1 % 4, k1 / 4, pix);
      end
      k1++; wc1++;
    end
    if (w2) begin
      n_vec++;
      assert (x2 === 2'(k2 % 4) && y2 === 1'(k2 / 4) && k2 < 8 && d2 === pix && pix[7:0] == 8'(x2) && pix[15:8] == 8'(y2)) else begin
        n_err++;
        $error("FAIL u2_wr k=%0d got x=%0d y=%0d d=%h exp x=%0d y=%0d d=%h", k2, x2, y2, d2, k2 % 4, k2 / 4, pix);
      end
      k2++; wc2++;
    end
    if (fd0) fc0++;
    if (fd1) fc1++;
    if (b0)  bc0++;
  endtask

  task automatic vs_low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0);
  endtask

  task automatic px(input int fid, input int ln, input int col);
    step(1'b1, 1'b1, {8'(fid), 8'(ln), 8'(col)});
  endtask

  // 8 active pixels followed by a 3-cycle HS-low gap
  task automatic line(input int fid, input int ln);
    for (int c = 0; c < 8; c++) px(fid, ln, c);
    for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 24'h0);
  endtask

  // Sync pulse, then 4 lines; the frame ends at the next vs_low
  task automatic frame(input int fid);
    vs_low(2);
    k0 = 0; k1 = 0; k2 = 0;
    step(1'b1, 1'b0, 24'h0);
    for (int l = 0; l < 4; l++) line(fid, l);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    iVGA_VS = 1'b0; iVGA_HS = 1'b0; iPIX = '0;
    k0 = 0; k1 = 0; k2 = 0;
    clr();
    @(negedge clk);

    // 1: reset and idle
    vs_low(2);
    chk("rst_write", int'(w0), 0);
    chk("rst_xy", int'({x0, y0}), 0);
    chk("rst_wdata", int'(d0), 0);
    chk("rst_busy", int'(b0), 0);
    chk("rst_fd", int'(fd0), 0);
    chk("rst_cnt", int'(c0), 0);
    reset = 1'b1;
    clr();
    frame(0);
    vs_low(2);
    chk("idle_writes", wc0, 0);
    chk("idle_busy", bc0, 0);

    // 2..4: single shot, start mid-frame; all three instances capture
    clr();
    step(1'b1, 1'b0, 24'h0);
    line(9, 0);
    start = 1'b1;
    line(9, 1);
    line(9, 2);
    chk("midframe_writes", wc0 + wc1 + wc2, 0);
    chk("armed_busy", int'(b0), 1);
    frame(1);
    vs_low(2);
    chk("ss_writes_u0", wc0, 32);
    chk("ss_writes_dec", wc1, 8);
    chk("ss_writes_crop", wc2, 8);
    chk("ss_fd_u0", fc0, 1);
    chk("ss_fd_dec", fc1, 1);
    chk("ss_cnt", int'(c0), 1);
    chk("ss_busy_end", int'(b0), 0);

    // 5: continuous over 3 frames, abort mid-frame 4
    reset = 1'b0;
    step(1'b0, 1'b0, 24'h0);
    reset = 1'b1;
    chk("rst2_cnt", int'(c0), 0);
    clr();
    continuous = 1'b1; start = 1'b1;
    step(1'b0, 1'b0, 24'h0);
    continuous = 1'b0;
    frame(1);
    frame(2);
    frame(3);
    vs_low(2);
    chk("cont_fd3", fc0, 3);
    k0 = 0; k1 = 0; k2 = 0;
    step(1'b1, 1'b0, 24'h0);
    line(4, 0);
    for (int c = 0; c < 3; c++) px(4, 1, c);
    chk("pre_abort_busy", int'(b0), 1);
    abort = 1'b1;
    px(4, 1, 3);
    chk("abort_write", int'(w0), 0);
    chk("abort_busy", int'(b0), 0);
    for (int c = 4; c < 8; c++) px(4, 1, c);
    for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 24'h0);
    vs_low(2);
    chk("cont_writes_u0", wc0, 107);
    chk("cont_writes_dec", wc1, 28);
    chk("cont_writes_crop", wc2, 31);
    chk("cont_fd", fc0, 3);
    chk("cont_cnt", int'(c0), 3);

    // 6: start+abort together, then reset mid-line, then a clean capture
    clr();
    start = 1'b1; abort = 1'b1;
    step(1'b0, 1'b0, 24'h0);
    frame(5);
    vs_low(2);
    chk("sa_writes", wc0, 0);
    chk("sa_busy", bc0, 0);
    chk("sa_cnt", int'(c0), 3);
    start = 1'b1;
    step(1'b0, 1'b0, 24'h0);
    vs_low(2);
    k0 = 0; k1 = 0; k2 = 0;
    step(1'b1, 1'b0, 24'h0);
    line(6, 0);
    for (int c = 0; c < 3; c++) px(6, 1, c);
    reset = 1'b0;
    px(6, 1, 3);
    chk("midrst_write", int'(w0), 0);
    chk("midrst_cnt", int'(c0), 0);
    chk("midrst_busy", int'(b0), 0);
    chk("midrst_wdata", int'(d0), 0);
    reset = 1'b1;
    for (int c = 4; c < 8; c++) px(6, 1, c);
    clr();
    start = 1'b1;
    step(1'b1, 1'b0, 24'h0);
    frame(7);
    vs_low(2);
    chk("post_writes_u0", wc0, 32);
    chk("post_writes_dec", wc1, 8);
    chk("post_writes_crop", wc2, 8);
    chk("post_fd", fc0, 1);
    chk("post_cnt", int'(c0), 1);
    chk("post_busy", int'(b0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
